// File: rtl/f3_offset_ram.sv
// f3_offset_ram
//   Offset store behind the GPU's RAM command interface. Keeps one wrapping
//   shift offset per tile row and per tile column of a 2**POS_W square grid.
//   It executes single-cycle shift commands and multi-cycle clears. It also
//   answers combinational offset lookups for the pixel mapper.
//
// Optional feature macro: MOVE_COUNT_EN
//   When defined, move_count counts accepted shifts and saturates at its top
//   value. It is zeroed whenever a clear starts.
//   When undefined, move_count is tied to 0.
//
// Ports
//   sysclk               system clock, all state on posedge
//   rst_n                asynchronous active-low reset
//   ram_write            one-cycle shift command strobe
//   ram_write_pos        row (horizontal=1) or column (horizontal=0) index
//   ram_write_horizontal 1: shift a row, 0: shift a column
//   ram_write_increase   1: offset+1, 0: offset-1 (wrapping)
//   ram_reset            level request to clear every offset
//   offset_pos_x         column index to look up
//   offset_pos_y         row index to look up
//   offset_x             stored offset of column offset_pos_x
//   offset_y             stored offset of row offset_pos_y
//   ram_busy             high while the clear sweep runs; writes are dropped
//   move_count           accepted shifts since the last clear
module f3_offset_ram #(
  parameter int POS_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             ram_write,
  input  logic [POS_W-1:0] ram_write_pos,
  input  logic             ram_write_horizontal,
  input  logic             ram_write_increase,
  input  logic             ram_reset,
  input  logic [POS_W-1:0] offset_pos_x,
  input  logic [POS_W-1:0] offset_pos_y,
  output logic [POS_W-1:0] offset_x,
  output logic [POS_W-1:0] offset_y,
  output logic             ram_busy,
  output logic [CNT_W-1:0] move_count
);

  localparam int DEPTH = 1 << POS_W;
  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_reg, state_next;
  logic [POS_W-1:0] clr_idx_reg, clr_idx_next;
  logic             accept;

  logic [POS_W-1:0] row_off_reg  [DEPTH];
  logic [POS_W-1:0] col_off_reg  [DEPTH];
  logic [POS_W-1:0] row_off_next [DEPTH];
  logic [POS_W-1:0] col_off_next [DEPTH];

  // Control: the clear request always beats a simultaneous shift strobe.
  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    accept       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ram_reset) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end else begin
          accept = ram_write;
        end
      end
      CLEAR: begin
        // Natural wrap lets a held ram_reset restart the sweep from entry 0.
        clr_idx_next = clr_idx_reg + POS_W'(1);
        if (clr_idx_reg == LAST_IDX && !ram_reset) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-entry next values: clear sweep first, otherwise the addressed shift.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      row_off_next[i] = row_off_reg[i];
      col_off_next[i] = col_off_reg[i];
      if (state_reg == CLEAR && clr_idx_reg == POS_W'(i)) begin
        row_off_next[i] = '0;
        col_off_next[i] = '0;
      end else if (accept && ram_write_pos == POS_W'(i)) begin
        if (ram_write_horizontal) begin
          row_off_next[i] = ram_write_increase ? row_off_reg[i] + POS_W'(1)
                                               : row_off_reg[i] - POS_W'(1);
        end else begin
          col_off_next[i] = ram_write_increase ? col_off_reg[i] + POS_W'(1)
                                               : col_off_reg[i] - POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      clr_idx_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        row_off_reg[i] <= '0;
        col_off_reg[i] <= '0;
      end
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
      for (int i = 0; i < DEPTH; i++) begin
        row_off_reg[i] <= row_off_next[i];
        col_off_reg[i] <= col_off_next[i];
      end
    end
  end

  assign ram_busy = (state_reg == CLEAR);
  assign offset_x = col_off_reg[offset_pos_x];
  assign offset_y = row_off_reg[offset_pos_y];

`ifdef MOVE_COUNT_EN
  logic [CNT_W-1:0] move_count_reg;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      move_count_reg <= '0;
    end else if (state_reg == IDLE && ram_reset) begin
      move_count_reg <= '0;
    end else if (accept && move_count_reg != '1) begin
      move_count_reg <= move_count_reg + CNT_W'(1);
    end
  end

  assign move_count = move_count_reg;
`else
  assign move_count = '0;
`endif

endmodule

// File: tb/tb_f3_offset_ram.sv
// Self-checking bench for f3_offset_ram: directed scenarios with literal
// expectations, then a randomized phase checked against a behavioural model.
module tb_f3_offset_ram;

  localparam int POS_W = 4;
  localparam int CNT_W = 16;
  localparam int N     = 16;

  logic             sysclk = 1'b0;
  logic             rst_n;
  logic             ram_write;
  logic [POS_W-1:0] ram_write_pos;
  logic             ram_write_horizontal;
  logic             ram_write_increase;
  logic             ram_reset;
  logic [POS_W-1:0] offset_pos_x;
  logic [POS_W-1:0] offset_pos_y;
  logic [POS_W-1:0] offset_x;
  logic [POS_W-1:0] offset_y;
  logic             ram_busy;
  logic [CNT_W-1:0] move_count;

  int n_tests = 0;
  int n_fail  = 0;

  f3_offset_ram #(.POS_W(POS_W), .CNT_W(CNT_W)) dut (
    .sysclk               (sysclk),
    .rst_n                (rst_n),
    .ram_write            (ram_write),
    .ram_write_pos        (ram_write_pos),
    .ram_write_horizontal (ram_write_horizontal),
    .ram_write_increase   (ram_write_increase),
    .ram_reset            (ram_reset),
    .offset_pos_x         (offset_pos_x),
    .offset_pos_y         (offset_pos_y),
    .offset_x             (offset_x),
    .offset_y             (offset_y),
    .ram_busy             (ram_busy),
    .move_count           (move_count)
  );

  always #5 sysclk = ~sysclk;

  // Behavioural model: plain arrays plus a "sweep position" for the clear.
  int m_row [N];
  int m_col [N];
  bit m_busy;
  int m_sweep;
  int m_moves;

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_row[i] <= 0;
        m_col[i] <= 0;
      end
      m_busy  <= 1'b0;
      m_sweep <= 0;
      m_moves <= 0;
    end else if (!m_busy) begin
      if (ram_reset) begin
        m_busy  <= 1'b1;
        m_sweep <= 0;
        m_moves <= 0;
      end else if (ram_write) begin
        if (ram_write_horizontal)
          m_row[ram_write_pos] <= (m_row[ram_write_pos] + (ram_write_increase ? 1 : N - 1)) % N;
        else
          m_col[ram_write_pos] <= (m_col[ram_write_pos] + (ram_write_increase ? 1 : N - 1)) % N;
        m_moves <= m_moves + 1;
      end
    end else begin
      m_row[m_sweep] <= 0;
      m_col[m_sweep] <= 0;
      if (m_sweep == N - 1 && !ram_reset) m_busy <= 1'b0;
      m_sweep <= (m_sweep + 1) % N;
    end
  end

  function automatic int exp_moves();
`ifdef MOVE_COUNT_EN
    return (m_moves > 65535) ? 65535 : m_moves;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare every observable output against the model.
  task automatic check_model();
    chk("model_offset_x", int'(offset_x), m_col[offset_pos_x]);
    chk("model_offset_y", int'(offset_y), m_row[offset_pos_y]);
    chk("model_busy", int'(ram_busy), int'(m_busy));
    chk("model_move_count", int'(move_count), exp_moves());
  endtask

  // One clock; outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge sysclk);
    @(negedge sysclk);
    check_model();
    $display("[TB] cyc wr=%0d pos=%0d h=%0d inc=%0d rr=%0d | x=%0d y=%0d busy=%0d cnt=%0d",
             ram_write, ram_write_pos, ram_write_horizontal, ram_write_increase,
             ram_reset, offset_x, offset_y, ram_busy, move_count);
  endtask

  task automatic drive(input bit wr, input int pos, input bit h, input bit inc, input bit rr);
    ram_write            = wr;
    ram_write_pos        = POS_W'(pos);
    ram_write_horizontal = h;
    ram_write_increase   = inc;
    ram_reset            = rr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    while (ram_busy && n < 100) begin
      n++;
      step();
    end
    if (ram_busy) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < N; i++) begin
      offset_pos_x = POS_W'(i);
      offset_pos_y = POS_W'(i);
      #1;
      chk({name, "_col"}, int'(offset_x), 0);
      chk({name, "_row"}, int'(offset_y), 0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    idle();
    offset_pos_x = '0;
    offset_pos_y = '0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    step();
    chk("reset_busy", int'(ram_busy), 0);
    chk("reset_count", int'(move_count), 0);
    check_all_zero("reset");

    // T2: row 3 decrements from 0 to 15, then back to 0.
    drive(1'b1, 3, 1'b1, 1'b0, 1'b0);
    offset_pos_y = 4'd3;
    step();
    idle();
    chk("t2_row_dec_wrap", int'(offset_y), 15);
    drive(1'b1, 3, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    chk("t2_row_inc_wrap", int'(offset_y), 0);

    // T3: 17 increments of column 15 wrap to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 15, 1'b0, 1'b1, 1'b0);
      step();
    end
    idle();
    offset_pos_x = 4'd15;
    #1;
    chk("t3_col15", int'(offset_x), 1);
    for (int i = 0; i < 15; i++) begin
      offset_pos_x = POS_W'(i);
      #1;
      chk("t3_other_col", int'(offset_x), 0);
    end
    for (int i = 0; i < N; i++) begin
      offset_pos_y = POS_W'(i);
      #1;
      chk("t3_rows", int'(offset_y), 0);
    end
    @(negedge sysclk);

    // T4: preload, one-cycle clear, count busy cycles, dropped write.
    drive(1'b1, 2, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 7, 1'b0, 1'b0, 1'b0); step();
    idle();
    offset_pos_y = 4'd2;
    offset_pos_x = 4'd7;
    #1;
    chk("t4_preload_row", int'(offset_y), 1);
    chk("t4_preload_col", int'(offset_x), 15);
    offset_pos_y = 4'd0;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    n = 0;
    while (ram_busy && n < 40) begin
      n++;
      // Row 0 is already cleared by the third busy cycle; a leak would show.
      if (n == 3) drive(1'b1, 0, 1'b1, 1'b1, 1'b0);
      else idle();
      step();
    end
    idle();
    chk("t4_busy_cycles", n, 16);
    check_all_zero("t4_cleared");
    chk("t4_count_zero", int'(move_count), 0);
    @(negedge sysclk);

    // T5: write and clear together; clear wins, row 5 untouched.
    drive(1'b1, 5, 1'b1, 1'b1, 1'b0); step();
    offset_pos_y = 4'd5;
    drive(1'b1, 5, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    chk("t5_busy", int'(ram_busy), 1);
    chk("t5_row5_untouched", int'(offset_y), 1);
    wait_not_busy("t5");

    // T6: dropped write in CLEAR, then 5 accepted shifts.
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 9, 1'b1, 1'b1, 1'b0); step();
    idle();
    wait_not_busy("t6");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i, i[0], 1'b1, 1'b0);
      step();
    end
    idle();
`ifdef MOVE_COUNT_EN
    chk("t6_count5", int'(move_count), 5);
`else
    chk("t6_count_off", int'(move_count), 0);
`endif
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1); step();
    idle();
    chk("t6_count_cleared", int'(move_count), 0);
    wait_not_busy("t6b");

    // Randomized phase, including held and mid-sweep clear requests.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 1) == 1), int'($urandom_range(0, N - 1)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 39) == 0));
      offset_pos_x = POS_W'($urandom_range(0, N - 1));
      offset_pos_y = POS_W'($urandom_range(0, N - 1));
      step();
    end
    idle();

    // T1: asynchronous reset mid-cycle clears everything immediately.
    drive(1'b1, 6, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 6, 1'b0, 1'b0, 1'b0); step();
    idle();
    offset_pos_x = 4'd6;
    offset_pos_y = 4'd6;
    @(posedge sysclk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_offset_x", int'(offset_x), 0);
    chk("t1_offset_y", int'(offset_y), 0);
    chk("t1_busy", int'(ram_busy), 0);
    chk("t1_count", int'(move_count), 0);
    check_model();
    @(negedge sysclk);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
